// File: rtl/status_register_unit.sv
// NZCV flag producer: captures S-instruction flags in EXE, holds them in a one-entry
// MEM slot, commits them to the architectural status register, and feeds ID and EXE.
module status_register_unit #(
  parameter bit         FORWARD = 1'b1,
  parameter logic [3:0] AL_COND = 4'b1110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       freeze,
  input  logic       flush,
  input  logic       exe_valid,
  input  logic       exe_s,
  input  logic [3:0] alu_flags,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  output logic       n,
  output logic       z,
  output logic       c,
  output logic       v,
  output logic       carry_in,
  output logic       stall,
  output logic [3:0] status_q
);

  logic       exe_hit;
  logic       pend_valid_reg, pend_valid_next;
  logic [3:0] pend_flags_reg, pend_flags_next;
  logic [3:0] status_reg, status_next;
  logic [3:0] id_flags;
  logic       hazard;

  assign exe_hit = exe_valid & exe_s & ~flush;

  always_comb begin
    pend_valid_next = pend_valid_reg;
    pend_flags_next = pend_flags_reg;
    status_next     = status_reg;
    if (!freeze) begin
      // Older instruction commits while the newer one enters the slot.
      pend_valid_next = exe_hit;
      pend_flags_next = alu_flags;
      if (pend_valid_reg) begin
        status_next = pend_flags_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_reg <= 1'b0;
      pend_flags_reg <= 4'b0000;
      status_reg     <= 4'b0000;
    end else begin
      pend_valid_reg <= pend_valid_next;
      pend_flags_reg <= pend_flags_next;
      status_reg     <= status_next;
    end
  end

  assign hazard = id_valid & (id_cond != AL_COND) & (exe_hit | pend_valid_reg);

  generate
    if (FORWARD) begin : g_forward
      always_comb begin
        id_flags = status_reg;
        if (exe_hit) begin
          id_flags = alu_flags;
        end else if (pend_valid_reg) begin
          id_flags = pend_flags_reg;
        end
      end
      assign stall = 1'b0 & hazard;
    end else begin : g_no_forward
      assign id_flags = status_reg;
      assign stall    = hazard;
    end
  endgenerate

  // Carry comes from registered state only, so ADC/SBC never loops through the ALU.
  assign carry_in = pend_valid_reg ? pend_flags_reg[1] : status_reg[1];

  assign {n, z, c, v} = id_flags;
  assign status_q     = status_reg;

endmodule

// File: tb/tb_status_register_unit.sv
// Bench for status_register_unit: directed scenarios plus randomized traffic against a
// queue-based flag model, run on a forwarding and a non-forwarding instance.
module tb_status_register_unit;

  logic       clk = 1'b0;
  logic       rst, freeze, flush, exe_valid, exe_s, id_valid;
  logic [3:0] alu_flags, id_cond;

  logic       n_f, z_f, c_f, v_f, carry_f, stall_f;
  logic [3:0] status_f;
  logic       n_s, z_s, c_s, v_s, carry_s, stall_s;
  logic [3:0] status_s;

  int checks = 0;
  int errors = 0;

  logic [3:0] status_m;
  logic [3:0] pend_q[$];

  always #5 clk = ~clk;

  status_register_unit #(.FORWARD(1'b1), .AL_COND(4'b1110)) dut_fwd (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .exe_valid(exe_valid), .exe_s(exe_s), .alu_flags(alu_flags),
    .id_valid(id_valid), .id_cond(id_cond),
    .n(n_f), .z(z_f), .c(c_f), .v(v_f),
    .carry_in(carry_f), .stall(stall_f), .status_q(status_f)
  );

  status_register_unit #(.FORWARD(1'b0), .AL_COND(4'b1110)) dut_stl (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .exe_valid(exe_valid), .exe_s(exe_s), .alu_flags(alu_flags),
    .id_valid(id_valid), .id_cond(id_cond),
    .n(n_s), .z(z_s), .c(c_s), .v(v_s),
    .carry_in(carry_s), .stall(stall_s), .status_q(status_s)
  );

  wire [3:0] id_f = {n_f, z_f, c_f, v_f};
  wire [3:0] id_s = {n_s, z_s, c_s, v_s};
  // Forwarding instance observation: {status_q, id flags, carry_in, stall}
  wire [9:0] obs_f = {status_f, id_f, carry_f, stall_f};
  wire [9:0] obs_s = {status_s, id_s, carry_s, stall_s};

  // Architectural model: flags in flight toward commit are a queue, commit pops it.
  task automatic model_edge();
    logic hit;
    hit = exe_valid & exe_s & ~flush;
    if (rst) begin
      pend_q.delete();
      status_m = 4'b0000;
    end else if (!freeze) begin
      if (pend_q.size() != 0) status_m = pend_q.pop_front();
      if (hit) pend_q.push_back(alu_flags);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] f);
    exe_valid = v;
    exe_s     = s;
    alu_flags = f;
    #1;
  endtask

  task automatic idle();
    exe_valid = 1'b0; exe_s = 1'b0; flush = 1'b0; freeze = 1'b0; rst = 1'b0;
    alu_flags = 4'b0000; id_valid = 1'b0; id_cond = 4'b1110;
  endtask

  task automatic test_reset();
    idle();
    alu_flags = 4'b1111; exe_valid = 1'b1; exe_s = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    idle();
    #1;
    checks++;
    if (obs_f !== 10'b0000_0000_0_0) begin
      errors++;
      $display("FAIL reset_fwd got %b want %b", obs_f, 10'b0);
    end
    checks++;
    if (obs_s !== 10'b0000_0000_0_0) begin
      errors++;
      $display("FAIL reset_stall got %b want %b", obs_s, 10'b0);
    end
  endtask

  task automatic test_commit();
    drive(1'b1, 1'b1, 4'b1010);
    checks++;
    if (obs_f !== {4'b0000, 4'b1010, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL commit_exe got %b want %b", obs_f, {4'b0000, 4'b1010, 1'b0, 1'b0});
    end
    tick();
    idle();
    #1;
    checks++;
    if (obs_f !== {4'b0000, 4'b1010, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL commit_mem got %b want %b", obs_f, {4'b0000, 4'b1010, 1'b1, 1'b0});
    end
    tick();
    checks++;
    if (obs_f !== {4'b1010, 4'b1010, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL commit_done got %b want %b", obs_f, {4'b1010, 4'b1010, 1'b1, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 4'b0100);
    checks++;
    if (obs_f !== {4'b1010, 4'b0100, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first got %b want %b", obs_f, {4'b1010, 4'b0100, 1'b1, 1'b0});
    end
    tick();
    drive(1'b1, 1'b1, 4'b0011);
    checks++;
    if (obs_f !== {4'b1010, 4'b0011, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second got %b want %b", obs_f, {4'b1010, 4'b0011, 1'b0, 1'b0});
    end
    tick();
    idle();
    #1;
    checks++;
    if (obs_f !== {4'b0100, 4'b0011, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_commit1 got %b want %b", obs_f, {4'b0100, 4'b0011, 1'b1, 1'b0});
    end
    tick();
    checks++;
    if (obs_f !== {4'b0011, 4'b0011, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_commit2 got %b want %b", obs_f, {4'b0011, 4'b0011, 1'b1, 1'b0});
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; id_valid = 1'b1; id_cond = 4'b0000;
    drive(1'b1, 1'b1, 4'b1111);
    checks++;
    if (obs_f !== {4'b0011, 4'b0011, 1'b1, 1'b0} || stall_s !== 1'b0) begin
      errors++;
      $display("FAIL flush_exe got %b stall %b want %b stall 0", obs_f, stall_s,
               {4'b0011, 4'b0011, 1'b1, 1'b0});
    end
    tick();
    idle();
    #1;
    checks++;
    if (obs_f !== {4'b0011, 4'b0011, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL flush_after got %b want %b", obs_f, {4'b0011, 4'b0011, 1'b1, 1'b0});
    end
  endtask

  task automatic test_freeze();
    drive(1'b1, 1'b1, 4'b0110);
    tick();
    idle();
    freeze = 1'b1;
    flush  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_f !== {4'b0011, 4'b0110, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL freeze_hold%0d got %b want %b", i, obs_f, {4'b0011, 4'b0110, 1'b1, 1'b0});
      end
    end
    freeze = 1'b0;
    flush  = 1'b0;
    tick();
    checks++;
    if (status_f !== 4'b0110 || status_s !== 4'b0110) begin
      errors++;
      $display("FAIL freeze_release got %b/%b want 0110", status_f, status_s);
    end
  endtask

  task automatic test_stall();
    id_valid = 1'b1; id_cond = 4'b0000;
    drive(1'b1, 1'b1, 4'b0101);
    checks++;
    if (obs_s !== {4'b0110, 4'b0110, 1'b1, 1'b1} || stall_f !== 1'b0) begin
      errors++;
      $display("FAIL stall_exe got %b fwdstall %b want %b fwdstall 0", obs_s, stall_f,
               {4'b0110, 4'b0110, 1'b1, 1'b1});
    end
    tick();
    drive(1'b0, 1'b0, 4'b0000);
    checks++;
    if (obs_s !== {4'b0110, 4'b0110, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL stall_mem got %b want %b", obs_s, {4'b0110, 4'b0110, 1'b0, 1'b1});
    end
    tick();
    checks++;
    if (obs_s !== {4'b0101, 4'b0101, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stall_clear got %b want %b", obs_s, {4'b0101, 4'b0101, 1'b0, 1'b0});
    end
    id_cond = 4'b1110;
    drive(1'b1, 1'b1, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall_s !== 1'b0) begin
        errors++;
        $display("FAIL stall_al%0d got %b want 0", i, stall_s);
      end
      tick();
      drive(1'b0, 1'b0, 4'b0000);
    end
    checks++;
    if (status_s !== 4'b1000) begin
      errors++;
      $display("FAIL stall_al_commit got %b want 1000", status_s);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 4'b1001);
    tick();
    idle();
    rst = 1'b1;
    freeze = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (obs_f !== 10'b0) begin
      errors++;
      $display("FAIL rstmid_now got %b want %b", obs_f, 10'b0);
    end
    tick();
    checks++;
    if (status_f !== 4'b0000 || status_s !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_nocommit got %b/%b want 0000", status_f, status_s);
    end
  endtask

  task automatic test_random();
    logic       hit;
    logic [3:0] held, exp_id, exp_status;
    logic       exp_carry, exp_stall;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 31) == 0);
      freeze    = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 5) == 0);
      exe_valid = ($urandom_range(0, 3) != 0);
      exe_s     = ($urandom_range(0, 2) != 0);
      alu_flags = 4'($urandom);
      id_valid  = $urandom_range(0, 1) == 1;
      id_cond   = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom);
      #1;
      hit  = exe_valid & exe_s & ~flush;
      held = (pend_q.size() != 0) ? pend_q[0] : status_m;
      exp_id     = hit ? alu_flags : held;
      exp_status = status_m;
      exp_carry  = held[1];
      exp_stall  = id_valid & (id_cond != 4'b1110) & (hit | (pend_q.size() != 0));
      checks++;
      if (obs_f !== {exp_status, exp_id, exp_carry, 1'b0}) begin
        errors++;
        $display("FAIL rand_fwd cycle %0d got %b want %b", i, obs_f,
                 {exp_status, exp_id, exp_carry, 1'b0});
      end
      checks++;
      if (obs_s !== {exp_status, exp_status, exp_carry, exp_stall}) begin
        errors++;
        $display("FAIL rand_stall cycle %0d got %b want %b", i, obs_s,
                 {exp_status, exp_status, exp_carry, exp_stall});
      end
      tick();
    end
    idle();
  endtask

  initial begin
    status_m = 4'b0000;
    idle();
    test_reset();
    test_commit();
    test_back_to_back();
    test_flush();
    test_freeze();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
